// File: rtl/dlc_pkg.sv
// rtl/dlc_pkg.sv - shared defaults, widths and state type for the delay line controller
package dlc_pkg;
  localparam int DEPTH_DFLT    = 16;
  localparam int HOLDOFF_DFLT  = 4;
  localparam int LOCK_CNT_DFLT = 8;
  localparam int TAP_W         = $clog2(DEPTH_DFLT);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;
endpackage

// File: rtl/dlc_delay_line.sv
// rtl/dlc_delay_line.sv - DEPTH-bit shift register with a registered tap mux
module dlc_delay_line import dlc_pkg::*; #(
  parameter int DEPTH = DEPTH_DFLT,
  parameter int TW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_in,
  input  logic [TW-1:0] tap_sel,
  output logic          d_out
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr    <= '0;
      d_out <= 1'b0;
    end else begin
      sr    <= {sr[DEPTH-2:0], data_in};
      d_out <= sr[tap_sel];
    end
  end

endmodule

// File: rtl/delay_line_controller.sv
// rtl/delay_line_controller.sv - tap selection FSM with settle holdoff and lock detection
module delay_line_controller import dlc_pkg::*; #(
  parameter int DEPTH    = DEPTH_DFLT,
  parameter int HOLDOFF  = HOLDOFF_DFLT,
  parameter int LOCK_CNT = LOCK_CNT_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_in,
  input  logic                     shift_left,
  input  logic                     shift_right,
  output logic                     d_out,
  output logic [$clog2(DEPTH)-1:0] tap_sel,
  output logic                     at_min,
  output logic                     at_max,
  output logic                     locked
);

  localparam int TW = $clog2(DEPTH);
  // Widths keep room for the full count value even when a parameter is 0.
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam int LW = $clog2(LOCK_CNT + 2);

  localparam logic [TW-1:0] TAP_MAX = TW'(DEPTH - 1);
  localparam logic [TW-1:0] TAP_RST = TW'(DEPTH / 2);
  localparam logic [HW-1:0] HOLD_V  = HW'(HOLDOFF);
  localparam logic [LW-1:0] LOCK_V  = LW'(LOCK_CNT);

  state_t          state, state_n;
  logic [TW-1:0]   tap_n;
  logic [HW-1:0]   hold, hold_n;
  logic [LW-1:0]   lock_cnt, lock_n;

  dlc_delay_line #(.DEPTH(DEPTH), .TW(TW)) u_line (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .tap_sel (tap_sel),
    .d_out   (d_out)
  );

  always_comb begin
    state_n = state;
    tap_n   = tap_sel;
    hold_n  = hold;
    lock_n  = '0;
    case (state)
      IDLE: begin
        if (!shift_left && !shift_right) begin
          lock_n = (lock_cnt == LOCK_V) ? lock_cnt : lock_cnt + 1'b1;
        end else if (shift_right && !shift_left && tap_sel != TAP_MAX) begin
          tap_n   = tap_sel + 1'b1;
          hold_n  = HOLD_V;
          state_n = SETTLE;
        end else if (shift_left && !shift_right && tap_sel != '0) begin
          tap_n   = tap_sel - 1'b1;
          hold_n  = HOLD_V;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        hold_n = (hold == '0) ? hold : hold - 1'b1;
        // Leave on the edge where the counter lands on zero.
        if (hold <= HW'(1)) begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tap_sel  <= TAP_RST;
      hold     <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      tap_sel  <= tap_n;
      hold     <= hold_n;
      lock_cnt <= lock_n;
      locked   <= (lock_n == LOCK_V);
    end
  end

  assign at_min = (tap_sel == '0);
  assign at_max = (tap_sel == TAP_MAX);

endmodule

// File: tb/tb_delay_line_controller.sv
// tb/tb_delay_line_controller.sv - self-checking bench for delay_line_controller
module tb_delay_line_controller;
  localparam int DEPTH    = 16;
  localparam int HOLDOFF  = 4;
  localparam int LOCK_CNT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b0;
  logic       shift_left = 1'b0;
  logic       shift_right = 1'b0;
  logic       d_out;
  logic [3:0] tap_sel;
  logic       at_min, at_max, locked;

  int errors = 0;
  int checks = 0;

  // Reference state: tap as an integer, edges still to ignore, quiet-edge
  // count, and the input history with the newest sample at the front.
  int m_tap = DEPTH / 2;
  int m_ignore = 0;
  int m_lock = 0;
  bit m_dout = 1'b0;
  bit m_hist[$];

  delay_line_controller #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .LOCK_CNT(LOCK_CNT)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .shift_left  (shift_left),
    .shift_right (shift_right),
    .d_out       (d_out),
    .tap_sel     (tap_sel),
    .at_min      (at_min),
    .at_max      (at_max),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit d, input bit l, input bit s);
    if (!r) begin
      m_tap = DEPTH / 2;
      m_ignore = 0;
      m_lock = 0;
      m_dout = 1'b0;
      m_hist.delete();
      for (int i = 0; i < DEPTH; i++) m_hist.push_back(1'b0);
    end else begin
      m_dout = m_hist[m_tap];
      m_hist.push_front(d);
      void'(m_hist.pop_back());
      if (m_ignore > 0) begin
        m_ignore--;
        m_lock = 0;
      end else if (!l && !s) begin
        m_lock = (m_lock < LOCK_CNT) ? m_lock + 1 : LOCK_CNT;
      end else begin
        m_lock = 0;
        if (s && !l && m_tap < DEPTH - 1) begin
          m_tap++;
          m_ignore = HOLDOFF;
        end else if (l && !s && m_tap > 0) begin
          m_tap--;
          m_ignore = HOLDOFF;
        end
      end
    end
  endtask

  // One clock: drive, take the edge, advance the model, compare 1ns later.
  task automatic cycle(input bit r, input bit d, input bit l, input bit s);
    rst = r; data_in = d; shift_left = l; shift_right = s;
    @(posedge clk);
    model_step(r, d, l, s);
    #1;
    chk("model_tap", int'(tap_sel), m_tap);
    chk("model_dout", int'(d_out), int'(m_dout));
    chk("model_locked", int'(locked), int'(m_lock == LOCK_CNT));
    chk("model_at_min", int'(at_min), int'(m_tap == 0));
    chk("model_at_max", int'(at_max), int'(m_tap == DEPTH - 1));
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
  endtask

  typedef struct {
    bit r, d, l, s;
    int tap;
    bit lk, mn, mx, dout;
  } vec_t;

  vec_t tbl[8];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_hist.push_back(1'b0);

    // Reset then holdoff: accept, ignore four held edges, accept again.
    tbl[0] = '{0, 0, 0, 0, 8, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 8, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 1, 9, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 1, 9, 0, 0, 0, 0};
    tbl[4] = '{1, 0, 0, 1, 9, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 0, 1, 9, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 1, 9, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 1, 10, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].r, tbl[i].d, tbl[i].l, tbl[i].s);
      chk($sformatf("tbl%0d_tap", i), int'(tap_sel), tbl[i].tap);
      chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
      chk($sformatf("tbl%0d_at_min", i), int'(at_min), int'(tbl[i].mn));
      chk($sformatf("tbl%0d_at_max", i), int'(at_max), int'(tbl[i].mx));
      chk($sformatf("tbl%0d_dout", i), int'(d_out), int'(tbl[i].dout));
    end

    // Latency at tap 8: pulse driven after edge k appears after edge k+10.
    do_reset();
    for (int j = 1; j <= 13; j++) begin
      cycle(1, j == 1, 0, 0);
      chk($sformatf("latency_%0d", j), int'(d_out), int'(j == 10));
    end

    // Saturation at tap 0; a refused shift leaves IDLE and clears lock.
    do_reset();
    for (int p = 0; p < 8; p++) begin
      cycle(1, 0, 1, 0);
      for (int q = 0; q < 5; q++) cycle(1, 0, 0, 0);
    end
    chk("sat_tap", int'(tap_sel), 0);
    chk("sat_at_min", int'(at_min), 1);
    cycle(1, 0, 1, 0);
    chk("sat_hold_tap", int'(tap_sel), 0);
    chk("sat_lock_clr", int'(locked), 0);
    for (int q = 0; q < 7; q++) cycle(1, 0, 0, 0);
    chk("sat_lock_7", int'(locked), 0);
    cycle(1, 0, 0, 1);
    chk("sat_no_settle", int'(tap_sel), 1);

    // Simultaneous request, then lock acquisition and loss.
    do_reset();
    cycle(1, 0, 1, 1);
    chk("both_tap", int'(tap_sel), 8);
    for (int q = 0; q < 7; q++) cycle(1, 0, 0, 0);
    chk("lock_after_7", int'(locked), 0);
    cycle(1, 0, 0, 0);
    chk("lock_after_8", int'(locked), 1);
    cycle(1, 0, 0, 1);
    chk("lock_lost", int'(locked), 0);
    chk("lock_lost_tap", int'(tap_sel), 9);

    // Reset during SETTLE aborts it.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      cycle(1, 0, 0, 1);
      if (p < 2) for (int q = 0; q < 5; q++) cycle(1, 0, 0, 0);
    end
    cycle(1, 0, 0, 0);
    chk("mid_tap11", int'(tap_sel), 11);
    cycle(0, 0, 0, 0);
    chk("mid_rst_tap", int'(tap_sel), 8);
    cycle(1, 0, 1, 0);
    chk("mid_release_tap", int'(tap_sel), 7);

    // Randomised traffic against the reference model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int sel;
      bit r;
      sel = $urandom_range(0, 15);
      r = ($urandom_range(0, 79) != 0);
      cycle(r, $urandom_range(0, 1) == 1, sel == 0 || sel == 2, sel == 1 || sel == 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
